core_alu_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single registered integer ALU between NREQ issue sources (e.g. integer pipe and address/branch unit).
- Accepts encoded ops over valid/ready, decodes each to the ALU's one-hot op select and steers operands into it.
- Captures the ALU result one cycle later and returns it to the originating requester through a per-requester held response slot.

---
 rtl/core_alu_pkg.sv | 55 +++++
 rtl/core_alu_opdec.sv | 20 ++
 rtl/core_alu_arb.sv | 170 +++++++++++++++++
 tb/tb_core_alu_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_alu_pkg.sv
// core_alu_pkg: shared ALU op indices and widths.
// Op index doubles as the one-hot ALU_SEL bit position.
package core_alu_pkg;

  localparam int N_OP = 38;
  localparam int OP_W = 6;

  typedef logic [OP_W-1:0] op_idx_t;

  localparam int OP_ADDI    = 0;
  localparam int OP_SLTI    = 1;
  localparam int OP_SLTIU   = 2;
  localparam int OP_XORI    = 3;
  localparam int OP_ORI     = 4;
  localparam int OP_ANDI    = 5;
  localparam int OP_SLLI    = 6;
  localparam int OP_SRLI    = 7;
  localparam int OP_SRAI    = 8;
  localparam int OP_ADD     = 9;
  localparam int OP_SUB     = 10;
  localparam int OP_SLL     = 11;
  localparam int OP_SLT     = 12;
  localparam int OP_SLTU    = 13;
  localparam int OP_XOR     = 14;
  localparam int OP_SRL     = 15;
  localparam int OP_SRA     = 16;
  localparam int OP_OR      = 17;
  localparam int OP_AND     = 18;
  localparam int OP_BEQ     = 19;
  localparam int OP_BNE     = 20;
  localparam int OP_BLT     = 21;
  localparam int OP_BGE     = 22;
  localparam int OP_BLTU    = 23;
  localparam int OP_BGEU    = 24;
  localparam int OP_LB      = 25;
  localparam int OP_LH      = 26;
  localparam int OP_LW      = 27;
  localparam int OP_LBU     = 28;
  localparam int OP_LHU     = 29;
  localparam int OP_SB      = 30;
  localparam int OP_SH      = 31;
  localparam int OP_SW      = 32;
  localparam int OP_FLW     = 33;
  localparam int OP_FSW     = 34;
  localparam int OP_FMVSX   = 35;
  localparam int OP_FSGNJXS = 36;
  localparam int OP_ROT     = 37;

  function automatic logic op_legal(
    input op_idx_t op
  );
    return int'(op) < N_OP;
  endfunction

endpackage

// File: rtl/core_alu_opdec.sv
// core_alu_opdec: op index to one-hot ALU select.
// All-zero output when disabled or index out of range.
module core_alu_opdec #(
  parameter int N_OP = core_alu_pkg::N_OP,
  parameter int OP_W = core_alu_pkg::OP_W
) (
  input  logic            EN,
  input  logic [OP_W-1:0] OP,
  output logic [N_OP-1:0] SEL
);

  // one select line per legal index
  always_comb begin
    SEL = '0;
    for (int i = 0; i < N_OP; i++) begin
      SEL[i] = EN && (OP == OP_W'(i));
    end
  end

endmodule

// File: rtl/core_alu_arb.sv
// core_alu_arb: round-robin sharing of the registered ALU.
// Define CORE_ALU_ARB_PERF_EN for PERF_BUSY/PERF_STALL counters.
module core_alu_arb #(
  parameter int NREQ = 2,
  parameter int N_OP = core_alu_pkg::N_OP,
  parameter int OP_W = core_alu_pkg::OP_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*OP_W-1:0] REQ_OP,
  input  logic [NREQ*32-1:0]   REQ_RS1,
  input  logic [NREQ*32-1:0]   REQ_RS2,
  input  logic [NREQ*32-1:0]   REQ_IMM,
  input  logic [NREQ*32-1:0]   REQ_FRS1,
  input  logic [NREQ*32-1:0]   REQ_FRS2,
  output logic [NREQ-1:0]      RSP_VALID,
  input  logic [NREQ-1:0]      RSP_READY,
  output logic [NREQ*32-1:0]   RSP_DATA,
  output logic [N_OP-1:0]      ALU_SEL,
  output logic [31:0]          ALU_RS1,
  output logic [31:0]          ALU_RS2,
  output logic [31:0]          ALU_IMM,
  output logic [31:0]          ALU_FRS1,
  output logic [31:0]          ALU_FRS2,
`ifdef CORE_ALU_ARB_PERF_EN
  output logic [31:0]          PERF_BUSY,
  output logic [31:0]          PERF_STALL,
`endif
  input  logic [31:0]          ALU_RESULT
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]      ptr_q;
  logic               inf_vld_q;
  logic [PW-1:0]      inf_id_q;
  logic               inf_ill_q;
  logic [NREQ-1:0]    rsp_vld_q;
  logic [NREQ*32-1:0] rsp_data_q;

  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    gnt;
  logic [PW-1:0]      win;
  logic [PW-1:0]      ptr_nxt;
  logic               gnt_any;
  logic [OP_W-1:0]    op_w;
  logic               op_ill;

  // eligible: valid, nothing in flight, slot free or draining
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = RST_N
             && REQ_VALID[i]
             && !(inf_vld_q && inf_id_q == PW'(i))
             && (!rsp_vld_q[i] || RSP_READY[i]);
    end
  end

  // first eligible index at or after ptr wins
  always_comb begin
    logic [PW-1:0] idx;
    gnt     = '0;
    win     = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_any && elig[idx]) begin
        gnt_any  = 1'b1;
        win      = idx;
        gnt[idx] = 1'b1;
      end
    end
    ptr_nxt = PW'((int'(win) + 1) % NREQ);
  end

  assign REQ_READY = gnt;

  // steer winner's op and operands to the ALU
  always_comb begin
    op_w     = '0;
    ALU_RS1  = '0;
    ALU_RS2  = '0;
    ALU_IMM  = '0;
    ALU_FRS1 = '0;
    ALU_FRS2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_w     = REQ_OP[i*OP_W +: OP_W];
        ALU_RS1  = REQ_RS1[i*32 +: 32];
        ALU_RS2  = REQ_RS2[i*32 +: 32];
        ALU_IMM  = REQ_IMM[i*32 +: 32];
        ALU_FRS1 = REQ_FRS1[i*32 +: 32];
        ALU_FRS2 = REQ_FRS2[i*32 +: 32];
      end
    end
  end

  assign op_ill = int'(op_w) >= N_OP;

  core_alu_opdec #(
    .N_OP (N_OP),
    .OP_W (OP_W)
  ) u_opdec (
    .EN  (gnt_any),
    .OP  (op_w),
    .SEL (ALU_SEL)
  );

  // pointer and in-flight tag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q     <= '0;
      inf_vld_q <= 1'b0;
      inf_id_q  <= '0;
      inf_ill_q <= 1'b0;
    end else begin
      inf_vld_q <= gnt_any;
      if (gnt_any) begin
        ptr_q     <= ptr_nxt;
        inf_id_q  <= win;
        inf_ill_q <= op_ill;
      end
    end
  end

  // response slots: fill from ALU beats a pending consume
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (inf_vld_q && inf_id_q == PW'(i)) begin
          rsp_vld_q[i] <= 1'b1;
          rsp_data_q[i*32 +: 32] <=
            inf_ill_q ? 32'd0 : ALU_RESULT;
        end else if (rsp_vld_q[i] && RSP_READY[i]) begin
          rsp_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  assign RSP_VALID = rsp_vld_q;
  assign RSP_DATA  = rsp_data_q;

`ifdef CORE_ALU_ARB_PERF_EN
  logic stall;

  assign stall = (|REQ_VALID) && !gnt_any;

  // saturating busy/stall counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PERF_BUSY  <= '0;
      PERF_STALL <= '0;
    end else begin
      if (gnt_any && PERF_BUSY != '1)
        PERF_BUSY <= PERF_BUSY + 32'd1;
      if (stall && PERF_STALL != '1)
        PERF_STALL <= PERF_STALL + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_alu_arb.sv
// tb_core_alu_arb: vector table plus corner sequences.
// Responses are checked against a scoreboard queue.
module tb_core_alu_arb;
  import core_alu_pkg::*;

  localparam int NREQ = 2;

  logic                 CLK;
  logic                 RST_N;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ-1:0]      REQ_READY;
  logic [NREQ*OP_W-1:0] REQ_OP;
  logic [NREQ*32-1:0]   REQ_RS1;
  logic [NREQ*32-1:0]   REQ_RS2;
  logic [NREQ*32-1:0]   REQ_IMM;
  logic [NREQ*32-1:0]   REQ_FRS1;
  logic [NREQ*32-1:0]   REQ_FRS2;
  logic [NREQ-1:0]      RSP_VALID;
  logic [NREQ-1:0]      RSP_READY;
  logic [NREQ*32-1:0]   RSP_DATA;
  logic [N_OP-1:0]      ALU_SEL;
  logic [31:0]          ALU_RS1;
  logic [31:0]          ALU_RS2;
  logic [31:0]          ALU_IMM;
  logic [31:0]          ALU_FRS1;
  logic [31:0]          ALU_FRS2;
  logic [31:0]          ALU_RESULT;
`ifdef CORE_ALU_ARB_PERF_EN
  logic [31:0]          PERF_BUSY;
  logic [31:0]          PERF_STALL;
`endif

  core_alu_arb #(
    .NREQ (NREQ)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_OP     (REQ_OP),
    .REQ_RS1    (REQ_RS1),
    .REQ_RS2    (REQ_RS2),
    .REQ_IMM    (REQ_IMM),
    .REQ_FRS1   (REQ_FRS1),
    .REQ_FRS2   (REQ_FRS2),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_DATA   (RSP_DATA),
    .ALU_SEL    (ALU_SEL),
    .ALU_RS1    (ALU_RS1),
    .ALU_RS2    (ALU_RS2),
    .ALU_IMM    (ALU_IMM),
    .ALU_FRS1   (ALU_FRS1),
    .ALU_FRS2   (ALU_FRS2),
`ifdef CORE_ALU_ARB_PERF_EN
    .PERF_BUSY  (PERF_BUSY),
    .PERF_STALL (PERF_STALL),
`endif
    .ALU_RESULT (ALU_RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // small registered ALU: a subset of ops is enough here
  function automatic logic [31:0] alu_f(
    input logic [N_OP-1:0] s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] im
  );
    logic [4:0] sh;
    sh = b[4:0];
    if (s[OP_ADDI]) return a + im;
    if (s[OP_ADD])  return a + b;
    if (s[OP_SUB])  return a - b;
    if (s[OP_XOR])  return a ^ b;
    if (s[OP_OR])   return a | b;
    if (s[OP_AND])  return a & b;
    if (s[OP_ROT])  return (a << sh) | (a >> (6'd32 - {1'b0, sh}));
    return 32'd0;
  endfunction

  always @(posedge CLK)
    ALU_RESULT <= alu_f(ALU_SEL, ALU_RS1, ALU_RS2, ALU_IMM);

  typedef struct {
    int          id;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    int          req;
    int          op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb[$];
  logic [31:0] cur_exp [NREQ];
  int          checks;
  int          failures;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input int          r,
    input int          op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] im,
    input logic [31:0] e
  );
    REQ_OP[r*OP_W +: OP_W] = OP_W'(op);
    REQ_RS1[r*32 +: 32]    = a;
    REQ_RS2[r*32 +: 32]    = b;
    REQ_IMM[r*32 +: 32]    = im;
    REQ_FRS1[r*32 +: 32]   = ~a;
    REQ_FRS2[r*32 +: 32]   = ~b;
    cur_exp[r]             = e;
    REQ_VALID[r]           = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // scoreboard: pop on consume, push on accept
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (RSP_VALID[i] && RSP_READY[i]) begin
          int k;
          k = -1;
          foreach (sb[j])
            if (k < 0 && sb[j].id == i) k = j;
          if (k < 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: req %0d data %h",
                     i, RSP_DATA[i*32 +: 32]);
          end else begin
            chk("rsp_data", 64'(RSP_DATA[i*32 +: 32]),
                64'(sb[k].data));
            sb.delete(k);
          end
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (REQ_VALID[i] && REQ_READY[i])
          sb.push_back('{i, cur_exp[i]});
    end
  end

  vec_t           tbl[9];
  logic [NREQ-1:0] seq[$];
  logic [NREQ-1:0] g;
  logic [63:0]    one;
  logic [N_OP-1:0] exp_sel;
  logic           pat[5];
  int             n;
  int             cyc;

  initial begin
    checks    = 0;
    failures  = 0;
    RST_N     = 1'b0;
    REQ_VALID = '1;
    REQ_OP    = '0;
    REQ_RS1   = '0;
    REQ_RS2   = '0;
    REQ_IMM   = '0;
    REQ_FRS1  = '0;
    REQ_FRS2  = '0;
    RSP_READY = '1;
    for (int i = 0; i < NREQ; i++) cur_exp[i] = '0;

    tbl[0] = '{0, OP_ADD,  32'd5,  32'd7, 32'd0, 32'd12};
    tbl[1] = '{1, OP_SUB,  32'd10, 32'd3, 32'd0, 32'd7};
    tbl[2] = '{0, OP_ADDI, 32'd100, 32'd9, 32'd23, 32'd123};
    tbl[3] = '{1, OP_XOR,  32'hF0F0, 32'h0FF0, 32'd0, 32'hFF00};
    tbl[4] = '{0, OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'd0,
               32'h0F000F00};
    tbl[5] = '{1, 45,      32'd8, 32'd9, 32'd0, 32'd0};
    tbl[6] = '{0, OP_OR,   32'd1, 32'd2, 32'd0, 32'd3};
    tbl[7] = '{1, 38,      32'd4, 32'd4, 32'd0, 32'd0};
    tbl[8] = '{1, OP_ROT,  32'h80000001, 32'd1, 32'd0,
               32'h00000003};

    #3;
    chk("rst_ready", 64'(REQ_READY), 64'd0);
    chk("rst_sel", 64'(ALU_SEL), 64'd0);
    chk("rst_rspv", 64'(RSP_VALID), 64'd0);
    chk("rst_data", 64'(RSP_DATA), 64'd0);
`ifdef CORE_ALU_ARB_PERF_EN
    chk("rst_busy", 64'(PERF_BUSY), 64'd0);
    chk("rst_stall", 64'(PERF_STALL), 64'd0);
`endif
    REQ_VALID = '0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // single ops from the vector table
    for (int t = 0; t < 9; t++) begin
      @(posedge CLK);
      #1;
      drive(tbl[t].req, tbl[t].op, tbl[t].rs1,
            tbl[t].rs2, tbl[t].imm, tbl[t].exp);
      one     = 64'd1 << tbl[t].op;
      exp_sel = (tbl[t].op < N_OP) ? one[N_OP-1:0] : '0;
      @(negedge CLK);
      chk("tbl_ready", 64'(REQ_READY),
          64'd1 << tbl[t].req);
      chk("tbl_sel", 64'(ALU_SEL), 64'(exp_sel));
      chk("tbl_rs1", 64'(ALU_RS1), 64'(tbl[t].rs1));
      @(posedge CLK);
      #1 REQ_VALID = '0;
      @(negedge CLK);
      chk("tbl_idle_sel", 64'(ALU_SEL), 64'd0);
      chk("tbl_rspv_t1", 64'(RSP_VALID), 64'd0);
      @(negedge CLK);
      chk("tbl_rspv_t2", 64'(RSP_VALID),
          64'd1 << tbl[t].req);
      chk("tbl_data",
          64'(RSP_DATA[tbl[t].req*32 +: 32]),
          64'(tbl[t].exp));
    end
    drain();

    // contention: strict alternation from ptr 0
    @(posedge CLK);
    #1;
    drive(0, OP_ADD, 32'd100, 32'd1, 32'd0, 32'd101);
    drive(1, OP_ADD, 32'd200, 32'd1, 32'd0, 32'd201);
    n   = 0;
    cyc = 0;
    for (int c = 0; c < 12 && n < 4; c++) begin
      @(negedge CLK);
      cyc++;
      g = REQ_READY;
      if (g != '0) begin
        seq.push_back(g);
        n++;
      end
      @(posedge CLK);
      #1;
      if (n == 4) REQ_VALID = '0;
      else begin
        if (g[0])
          drive(0, OP_ADD, 32'(100 + n), 32'd1,
                32'd0, 32'(101 + n));
        if (g[1])
          drive(1, OP_ADD, 32'(200 + n), 32'd1,
                32'd0, 32'(201 + n));
      end
    end
    REQ_VALID = '0;
    chk("cont_cycles", 64'(cyc), 64'd4);
    chk("cont_g0", 64'(seq[0]), 64'd1);
    chk("cont_g1", 64'(seq[1]), 64'd2);
    chk("cont_g2", 64'(seq[2]), 64'd1);
    chk("cont_g3", 64'(seq[3]), 64'd2);
    drain();

    // backpressure on requester 0
    @(posedge CLK);
    #1;
    RSP_READY[0] = 1'b0;
    drive(0, OP_SUB, 32'd10, 32'd3, 32'd0, 32'd7);
    @(negedge CLK);
    chk("bp_grant", 64'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1 REQ_VALID = '0;
    repeat (2) @(negedge CLK);
    chk("bp_rspv", 64'(RSP_VALID), 64'd1);
    chk("bp_data", 64'(RSP_DATA[31:0]), 64'd7);
    @(posedge CLK);
    #1 drive(0, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("bp_blocked", 64'(REQ_READY), 64'd0);
      chk("bp_hold", 64'(RSP_DATA[31:0]), 64'd7);
    end
    @(posedge CLK);
    #1 RSP_READY[0] = 1'b1;
    @(negedge CLK);
    chk("bp_accept", 64'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1 REQ_VALID = '0;
    drain();

    // reset one cycle after a grant
    @(posedge CLK);
    #1;
    RSP_READY[1] = 1'b0;
    drive(1, OP_ADD, 32'd3, 32'd4, 32'd0, 32'd7);
    @(negedge CLK);
    chk("mr_g1", 64'(REQ_READY), 64'd2);
    @(posedge CLK);
    #1 REQ_VALID = '0;
    repeat (2) @(negedge CLK);
    chk("mr_held", 64'(RSP_VALID), 64'd2);
    @(posedge CLK);
    #1 drive(0, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12);
    @(negedge CLK);
    chk("mr_g0", 64'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1 REQ_VALID = '0;
    #1 RST_N = 1'b0;
    REQ_VALID = '1;
    #1;
    chk("mr_rspv", 64'(RSP_VALID), 64'd0);
    chk("mr_data", 64'(RSP_DATA), 64'd0);
    chk("mr_ready", 64'(REQ_READY), 64'd0);
    chk("mr_sel", 64'(ALU_SEL), 64'd0);
    REQ_VALID = '0;
    RSP_READY = '1;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("mr_quiet", 64'(RSP_VALID), 64'd0);
    end

    // one requester: grant every other cycle
    @(posedge CLK);
    #1 drive(0, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      pat[c] = REQ_READY[0];
    end
    @(posedge CLK);
    #1 REQ_VALID = '0;
    chk("rate_c0", 64'(pat[0]), 64'd1);
    chk("rate_c1", 64'(pat[1]), 64'd0);
    chk("rate_c2", 64'(pat[2]), 64'd1);
    chk("rate_c3", 64'(pat[3]), 64'd0);
    chk("rate_c4", 64'(pat[4]), 64'd1);
    @(negedge CLK);
`ifdef CORE_ALU_ARB_PERF_EN
    chk("perf_busy", 64'(PERF_BUSY), 64'd3);
    chk("perf_stall", 64'(PERF_STALL), 64'd2);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
